fetch_bus_responder: RTL
========================

Name: fetch_bus_responder

Overview:
- Instruction-side bus responder: the slave end of the fetch read interface (addr/read_req in, FETCH_WIDTH-wide data/ack out).
- Holds an on-chip instruction memory, loaded through a simple write port.
- Returns FETCH_WIDTH consecutive 32-bit words per accepted request after a configurable latency.
- Sits between the fetch stage and the instruction memory model; used in core-level simulation and FPGA bring-up.

Parameters:
- ADDR_WIDTH, 32, byte address width.
- INSTRUCTION_WIDTH, 32, bits per instruction word.
- FETCH_WIDTH, 4, words returned per response.
- MEM_WORDS, 4096, depth of the instruction array in words (power of two).
- BASE_ADDR, 32'h80000000, byte address of word 0.
- LATENCY, 1, cycles from accept to ack (>=1).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- fetch_bus_addr  in  ADDR_WIDTH  request byte address.
- fetch_bus_read_req  in  1  read request.
- bus_fetch_data  out  INSTRUCTION_WIDTH*FETCH_WIDTH  lane i at bits [32*i +: 32].
- bus_fetch_read_ack  out  1  data valid, one-cycle pulse per accepted request.
- load_addr  in  ADDR_WIDTH  byte address of loader write.
- load_data  in  INSTRUCTION_WIDTH  loader write data.
- load_we  in  1  loader write enable.
- resp_range_err  out  1  high with ack if any lane was out of range.
- resp_count  out  32  number of acks issued; wraps at 2^32.

Behaviour:
- Reset (rst sampled high at posedge): state=IDLE, bus_fetch_read_ack=0, bus_fetch_data=0, resp_range_err=0, resp_count=0. The memory array is not reset.
- Reset mid-operation discards any pending request. No ack is issued for it.
- Ready condition: state is IDLE or RESP.
- Accept: fetch_bus_read_req=1 while ready at a posedge. On accept, latch fetch_bus_addr.
- Requests present in WAIT are ignored, not queued. The initiator must re-present them.
- FSM transitions:
  - IDLE: on accept, go to RESP if LATENCY==1; otherwise go to WAIT with cnt=LATENCY-2.
  - WAIT: if cnt==0, go to RESP; otherwise decrement cnt.
  - RESP: ack=1 for this cycle. On accept, go to RESP/WAIT as from IDLE; otherwise go to IDLE.
- Timing:
  - Request accepted in cycle t gets its ack in cycle t+LATENCY.
  - With LATENCY=1 and req held high, ack is high every cycle (full throughput).
  - With LATENCY=N, throughput is one response per N cycles.
- bus_fetch_read_ack=0 in IDLE and WAIT. bus_fetch_data holds its last value when ack=0.
- Addressing:
  - Word index w = (addr - BASE_ADDR) >> 2, computed as unsigned ADDR_WIDTH arithmetic. Low 2 bits are ignored; misalignment is the fetch stage's concern.
  - Lane i reads word w+i. If w+i >= MEM_WORDS (including wrap from addr < BASE_ADDR), that lane returns 0 and resp_range_err=1 for that response.
  - Lanes do not wrap within the array.
- Data is registered. The array is read in the cycle preceding the RESP cycle, i.e. the posedge that enters RESP.
- Loader write:
  - load_we=1 writes mem[(load_addr-BASE_ADDR)>>2] at posedge.
  - Out-of-range loader writes are dropped silently.
  - A loader write to a word read at the same posedge returns the old data (read-before-write).
  - Loader writes are accepted in every state, including during reset.
- resp_count increments by 1 at each posedge that enters RESP.

Test Plan:
- Back-to-back reads:
  - Setup: LATENCY=1; load words 0..7 with 0x00000013+i.
  - Stimulus: req=1 with addr 0x80000000 at t, then 0x80000010 at t+1.
  - Required: ack at t+1 with data {0x16,0x15,0x14,0x13} (lane3..lane0); ack at t+2 with {0x1A,0x19,0x18,0x17}; resp_count=2.
- Wait states:
  - Setup: LATENCY=3.
  - Stimulus: req at t for 0x80000004, held high with addr changing each cycle.
  - Required: ack only at t+3 with lanes mem[1..4]. Next accept happens at t+3; the next ack is at t+6.
- Array end:
  - Setup: MEM_WORDS=4096.
  - Stimulus: addr 0x80003FF8.
  - Required: lanes 0,1 = mem[4094], mem[4095]; lanes 2,3 = 0; resp_range_err=1.
  - Also: addr 0x7FFFFFFC gives all lanes 0 and resp_range_err=1.
- Read/write collision:
  - Stimulus: load_we writes 0xDEADBEEF to word 0 at the same posedge a read of 0x80000000 enters RESP.
  - Required: that ack returns the old mem[0]; the next read returns 0xDEADBEEF.
- Reset mid-operation:
  - Setup: LATENCY=4.
  - Stimulus: accept at t; rst=1 at t+2.
  - Required: no ack in t+2..t+8; outputs are 0 and resp_count=0 after reset; memory contents are preserved on the next read.
- Unaligned address:
  - Stimulus: addr 0x80000006.
  - Required: returns the same lanes as 0x80000004.

Source files
------------

// File: rtl/fetch_bus_responder.sv
// fetch_bus_responder
//   Slave end of the instruction fetch read bus. It holds an on-chip
//   instruction array that is filled through a loader write port. Each
//   accepted request returns FETCH_WIDTH consecutive words, LATENCY cycles
//   after the accept.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   fetch_bus_addr      request byte address (low two bits ignored)
//   fetch_bus_read_req  read request, taken whenever the responder is not waiting
//   bus_fetch_data      FETCH_WIDTH words, lane i at [INSTRUCTION_WIDTH*i +: INSTRUCTION_WIDTH]
//   bus_fetch_read_ack  one-cycle pulse per accepted request
//   load_addr/_data/_we loader write port (writes in every state, including reset)
//   resp_range_err      with ack: at least one lane fell outside the array
//   resp_count          number of acks issued, wraps at 2^32
module fetch_bus_responder #(
  parameter int                    ADDR_WIDTH        = 32,
  parameter int                    INSTRUCTION_WIDTH = 32,
  parameter int                    FETCH_WIDTH       = 4,
  parameter int                    MEM_WORDS         = 4096,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR         = 32'h80000000,
  parameter int                    LATENCY           = 1
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [ADDR_WIDTH-1:0]                  fetch_bus_addr,
  input  logic                                   fetch_bus_read_req,
  output logic [INSTRUCTION_WIDTH*FETCH_WIDTH-1:0] bus_fetch_data,
  output logic                                   bus_fetch_read_ack,
  input  logic [ADDR_WIDTH-1:0]                  load_addr,
  input  logic [INSTRUCTION_WIDTH-1:0]           load_data,
  input  logic                                   load_we,
  output logic                                   resp_range_err,
  output logic [31:0]                            resp_count
);

  localparam int IDX_W = $clog2(MEM_WORDS);
  localparam int LW    = ADDR_WIDTH + 1;
  localparam int DW    = INSTRUCTION_WIDTH * FETCH_WIDTH;
  localparam int CNT_W = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
  // WAIT counts down from LATENCY-2 so that RESP is entered LATENCY-1 edges after the accept.
  localparam logic [CNT_W-1:0] CNT_INIT = (LATENCY >= 2) ? CNT_W'(LATENCY - 2) : '0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t                        state_q, state_d;
  logic [CNT_W-1:0]              cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]         addr_q;
  logic [DW-1:0]                 data_q;
  logic                          err_q;
  logic [31:0]                   count_q;
  logic                          accept;
  logic                          enter_resp;

  logic [ADDR_WIDTH-1:0]         rd_addr, rd_off, rd_word;
  logic [LW-1:0]                 lane_w;
  logic [DW-1:0]                 rd_data;
  logic                          rd_err;
  logic [ADDR_WIDTH-1:0]         wr_off, wr_word;
  logic                          wr_ok;

  logic [INSTRUCTION_WIDTH-1:0]  mem [MEM_WORDS];

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    case (state_q)
      S_IDLE, S_RESP: begin
        accept = fetch_bus_read_req;
        if (fetch_bus_read_req) begin
          if (LATENCY == 1) begin
            state_d = S_RESP;
          end else begin
            state_d = S_WAIT;
            cnt_d   = CNT_INIT;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) state_d = S_RESP;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign enter_resp = (state_d == S_RESP);
  // RESP is entered from WAIT with the latched address, otherwise (LATENCY==1)
  // it is entered on the accepting edge itself with the live address.
  assign rd_addr    = (state_q == S_WAIT) ? addr_q : fetch_bus_addr;

  // Lane read: out-of-range lanes (including wrap below BASE_ADDR) read as zero.
  always_comb begin
    rd_off  = rd_addr - BASE_ADDR;
    rd_word = rd_off >> 2;
    rd_data = '0;
    rd_err  = 1'b0;
    lane_w  = '0;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      lane_w = {1'b0, rd_word} + LW'(i);
      if (lane_w < LW'(MEM_WORDS)) begin
        rd_data[i*INSTRUCTION_WIDTH +: INSTRUCTION_WIDTH] = mem[lane_w[IDX_W-1:0]];
      end else begin
        rd_err = 1'b1;
      end
    end
  end

  assign wr_off  = load_addr - BASE_ADDR;
  assign wr_word = wr_off >> 2;
  assign wr_ok   = (wr_word < ADDR_WIDTH'(MEM_WORDS));

  // State / response registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (enter_resp) begin
        data_q  <= rd_data;
        err_q   <= rd_err;
        count_q <= count_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) addr_q <= fetch_bus_addr;
  end

  // Array write: the read above samples the pre-edge contents, so a same-edge
  // collision returns the old word.
  always_ff @(posedge clk) begin
    if (load_we && wr_ok) mem[wr_word[IDX_W-1:0]] <= load_data;
  end

  assign bus_fetch_data     = data_q;
  assign bus_fetch_read_ack = (state_q == S_RESP);
  assign resp_range_err     = err_q & (state_q == S_RESP);
  assign resp_count         = count_q;

endmodule
